// File: rtl/dmem_arbiter.sv
// Round-robin share of one data-memory port between the core load/store path (p0) and the loader (p1).
// Define DMEM_ARB_LOCK_EN to let p1 hold the bus across consecutive grants with p1_lock.
module dmem_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic          clock,
    input  logic          reset_n,

    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    input  logic [1:0]    p0_size,
    input  logic          p0_sext,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,

    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    input  logic [1:0]    p1_size,
    input  logic          p1_sext,
    input  logic          p1_lock,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,

    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [1:0]    mem_size,
    output logic          mem_sext,
    input  logic [DW-1:0] mem_rdata,

    output logic          busy
);

    logic                   rr_ptr;
    logic                   gnt0, gnt1, any_gnt, rr_upd;
    logic [MEM_LATENCY-1:0] pipe_vld, pipe_port;
    logic [DW-1:0]          rdata0_q, rdata1_q;

`ifdef DMEM_ARB_LOCK_EN
    logic lock_held;

    // While locked, p1 owns the port outright and the round-robin pointer is frozen.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (lock_held) begin
            gnt1 = p1_req;
        end else if (p0_req && p1_req) begin
            gnt0 = ~rr_ptr;
            gnt1 = rr_ptr;
        end else begin
            gnt0 = p0_req;
            gnt1 = p1_req;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)            lock_held <= 1'b0;
        else if (lock_held)      lock_held <= p1_lock;
        else if (gnt1 && p1_lock) lock_held <= 1'b1;
    end

    assign rr_upd = any_gnt & ~lock_held;
`else
    logic unused_lock;
    assign unused_lock = p1_lock;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (p0_req && p1_req) begin
            gnt0 = ~rr_ptr;
            gnt1 = rr_ptr;
        end else begin
            gnt0 = p0_req;
            gnt1 = p1_req;
        end
    end

    assign rr_upd = any_gnt;
`endif

    assign any_gnt = gnt0 | gnt1;
    assign p0_gnt  = gnt0;
    assign p1_gnt  = gnt1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)    rr_ptr <= 1'b0;
        else if (rr_upd) rr_ptr <= gnt0;   // point at the port that lost
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_size  = 2'd0;
        mem_sext  = 1'b0;
        if (gnt0) begin
            mem_we    = p0_we & p0_req;
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
            mem_size  = p0_size;
            mem_sext  = p0_sext;
        end else if (gnt1) begin
            mem_we    = p1_we & p1_req;
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
            mem_size  = p1_size;
            mem_sext  = p1_sext;
        end
    end

    // Writes occupy a slot as an empty bubble so returns stay aligned to grant order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pipe_vld  <= '0;
            pipe_port <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            pipe_vld[0]  <= any_gnt & ~mem_we;
            pipe_port[0] <= gnt1;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_port[i] <= pipe_port[i-1];
            end
            if (p0_rvalid) rdata0_q <= mem_rdata;
            if (p1_rvalid) rdata1_q <= mem_rdata;
        end
    end

    assign p0_rvalid = pipe_vld[MEM_LATENCY-1] & ~pipe_port[MEM_LATENCY-1];
    assign p1_rvalid = pipe_vld[MEM_LATENCY-1] &  pipe_port[MEM_LATENCY-1];

    // Returning data flows straight through; the held copy covers the idle cycles.
    assign p0_rdata = p0_rvalid ? mem_rdata : rdata0_q;
    assign p1_rdata = p1_rvalid ? mem_rdata : rdata1_q;

    assign busy = |pipe_vld;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed stimulus with a per-port scoreboard of expected read returns.
// A small synchronous memory model with MEM_LATENCY cycles of read delay sits behind the DUT.
module tb_dmem_arbiter;
    localparam int LAT = 3;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        p0_req, p0_we, p0_sext, p0_gnt, p0_rvalid;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic [1:0]  p0_size;
    logic        p1_req, p1_we, p1_sext, p1_lock, p1_gnt, p1_rvalid;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic [1:0]  p1_size;
    logic        mem_we, mem_sext, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_size;

    always #5 clock = ~clock;

    dmem_arbiter #(.AW(32), .DW(32), .MEM_LATENCY(LAT)) dut (
        .clock(clock), .reset_n(reset_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_size(p0_size), .p0_sext(p0_sext), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
        .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_size(p1_size), .p1_sext(p1_sext), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
        .p1_rdata(p1_rdata), .p1_lock(p1_lock),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size),
        .mem_sext(mem_sext), .mem_rdata(mem_rdata), .busy(busy)
    );

    // memory model
    logic [31:0] mem [0:63];
    logic [31:0] raddr_d [LAT];
    always @(posedge clock) begin
        if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
        raddr_d[0] <= mem_addr;
        for (int i = 1; i < LAT; i++) raddr_d[i] <= raddr_d[i-1];
    end
    assign mem_rdata = mem[raddr_d[LAT-1][7:2]];

    typedef struct { logic [31:0] data; int due; } exp_t;
    exp_t        q0[$], q1[$];
    int          cyc = 0, errs = 0, checks = 0;
    logic [31:0] last0 = '0, last1 = '0;
    bit          mon_on = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit busy_exp();
        busy_exp = 1'b0;
        foreach (q0[i]) if (q0[i].due - LAT < cyc && cyc <= q0[i].due) busy_exp = 1'b1;
        foreach (q1[i]) if (q1[i].due - LAT < cyc && cyc <= q1[i].due) busy_exp = 1'b1;
    endfunction

    // monitor: pops expected returns when due, otherwise checks rdata is held
    always @(negedge clock) begin
        if (mon_on) begin
            bit e0, e1;
            chk("busy", {31'd0, busy}, {31'd0, busy_exp()});
            e0 = (q0.size() > 0) && (q0[0].due == cyc);
            e1 = (q1.size() > 0) && (q1[0].due == cyc);
            if (e0 || p0_rvalid) begin
                chk("p0_rvalid", {31'd0, p0_rvalid}, {31'd0, e0});
                if (e0) begin
                    chk("p0_rdata", p0_rdata, q0[0].data);
                    last0 = q0[0].data;
                    void'(q0.pop_front());
                end
            end else chk("p0_rdata_hold", p0_rdata, last0);
            if (e1 || p1_rvalid) begin
                chk("p1_rvalid", {31'd0, p1_rvalid}, {31'd0, e1});
                if (e1) begin
                    chk("p1_rdata", p1_rdata, q1[0].data);
                    last1 = q1[0].data;
                    void'(q1.pop_front());
                end
            end else chk("p1_rdata_hold", p1_rdata, last1);
        end
    end

    // wait to the negedge of the current cycle, check grants, queue expected read data
    task automatic sample(input logic [1:0] eg, input logic [31:0] d0, input logic [31:0] d1);
        @(negedge clock);
        chk("gnt", {30'd0, p1_gnt, p0_gnt}, {30'd0, eg});
        if (eg[0] && !p0_we) q0.push_back('{d0, cyc + LAT});
        if (eg[1] && !p1_we) q1.push_back('{d1, cyc + LAT});
    endtask

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_in();
        p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0; p0_size = 0; p0_sext = 0;
        p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0; p1_size = 0; p1_sext = 0;
        p1_lock = 0;
    endtask

    task automatic idle(input int n);
        clear_in();
        for (int i = 0; i < n; i++) begin
            sample(2'b00, 0, 0);
            next();
        end
    endtask

    task automatic check_zero(input string tag);
        @(negedge clock);
        chk({tag, "_gnt_rv"}, {28'd0, p1_gnt, p0_gnt, p1_rvalid, p0_rvalid}, 32'd0);
        chk({tag, "_p0_rdata"}, p0_rdata, 32'd0);
        chk({tag, "_p1_rdata"}, p1_rdata, 32'd0);
        chk({tag, "_mem_ctl"}, {27'd0, mem_we, mem_size, mem_sext, busy}, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0] = 32'h11111111; mem[1] = 32'h22222222; mem[2] = 32'h33333333;
        mem[4] = 32'h12345678;
        clear_in();
        next();
        check_zero("reset");
        next();
        reset_n = 1'b1;
        mon_on  = 1'b1;

        // contention from reset: strict alternation starting with p0
        p0_req = 1; p0_addr = 32'h10; p0_size = 2;
        p1_req = 1; p1_addr = 32'h00; p1_size = 2;
        for (int i = 0; i < 6; i++) begin
            sample((i % 2 == 0) ? 2'b01 : 2'b10, 32'h12345678, 32'h11111111);
            next();
        end
        idle(LAT + 1);

        // single p0 read, word size
        p0_req = 1; p0_addr = 32'h10; p0_size = 2;
        sample(2'b01, 32'h12345678, 0);
        chk("single_mem_addr", mem_addr, 32'h10);
        chk("single_mem_ctl", {29'd0, mem_we, mem_size}, {29'd0, 1'b0, 2'd2});
        next();
        idle(LAT + 1);

        // back-to-back p1 reads; first one carries the invalid size with sign-extend
        p1_req = 1; p1_addr = 32'h0; p1_size = 3; p1_sext = 1;
        sample(2'b10, 0, 32'h11111111);
        chk("size3_pass", {29'd0, mem_size, mem_sext}, {29'd0, 2'd3, 1'b1});
        next();
        p1_addr = 32'h4; p1_size = 2; p1_sext = 0;
        sample(2'b10, 0, 32'h22222222);
        next();
        p1_addr = 32'h8;
        sample(2'b10, 0, 32'h33333333);
        next();
        idle(LAT + 1);

        // p0 word write, then p1 reads it back
        p0_req = 1; p0_we = 1; p0_addr = 32'h20; p0_wdata = 32'hDEADBEEF; p0_size = 2;
        sample(2'b01, 0, 0);
        chk("wr_mem_we", {31'd0, mem_we}, 32'd1);
        chk("wr_mem_addr", mem_addr, 32'h20);
        chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
        next();
        clear_in();
        p1_req = 1; p1_addr = 32'h20; p1_size = 2;
        sample(2'b10, 0, 32'hDEADBEEF);
        chk("rd_mem_we", {31'd0, mem_we}, 32'd0);
        next();
        idle(LAT + 1);

        // p0 alone first so the pointer favours p1 going into the lock sequence
        p0_req = 1; p0_addr = 32'h10;
        sample(2'b01, 32'h12345678, 0);
        next();
`ifdef DMEM_ARB_LOCK_EN
        p1_req = 1; p1_lock = 1; p1_addr = 32'h4;
        for (int i = 0; i < 4; i++) begin
            sample(2'b10, 0, 32'h22222222);
            next();
        end
        p1_req = 0; p1_lock = 0;
        sample(2'b00, 0, 0);
        next();
        sample(2'b01, 32'h12345678, 0);
        next();
`else
        p1_req = 1; p1_lock = 1; p1_addr = 32'h4;
        sample(2'b10, 0, 32'h22222222);
        next();
        sample(2'b01, 32'h12345678, 0);
        next();
`endif
        idle(LAT + 1);

        // reset while a p0 read is in flight
        p0_req = 1; p0_addr = 32'h10;
        sample(2'b01, 32'h12345678, 0);
        next();
        clear_in();
        reset_n = 1'b0;
        q0.delete(); q1.delete();
        last0 = '0; last1 = '0;
        check_zero("midreset");
        next();
        next();
        reset_n = 1'b1;
        for (int i = 0; i < LAT + 2; i++) begin
            @(negedge clock);
            chk("post_reset_p0_rvalid", {31'd0, p0_rvalid}, 32'd0);
            next();
        end
        p0_req = 1; p0_addr = 32'h10; p1_req = 1; p1_addr = 32'h8;
        sample(2'b01, 32'h12345678, 0);
        next();
        idle(LAT + 2);

        chk("q_drained", q0.size() + q1.size(), 32'd0);
        mon_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data memory port (address, write data, write enable, size, sign-extend, read data) between two requesters.
- Requester 0 is the core load/store path, driven from ALU result, RF reg_2 and decode-control memory signals.
- Requester 1 is the program/debug loader port.
- Round-robin arbitration, one grant per cycle, pipelined reads with per-port return routing.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MEM_LATENCY, 1, cycles from grant to valid mem_rdata; legal range 1..4.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- p0_req  in  1  requester 0 access request.
- p0_we  in  1  requester 0 write (1) / read (0).
- p0_addr  in  AW  requester 0 byte address.
- p0_wdata  in  DW  requester 0 store data.
- p0_size  in  2  requester 0 access size: 0 = byte, 1 = half, 2 = word.
- p0_sext  in  1  requester 0 sign-extend loads.
- p0_gnt  out  1  requester 0 request accepted this cycle.
- p0_rvalid  out  1  requester 0 read data valid.
- p0_rdata  out  DW  requester 0 read data.
- p1_req, p1_we, p1_addr, p1_wdata, p1_size, p1_sext, p1_gnt, p1_rvalid, p1_rdata: same as requester 0, for requester 1.
- p1_lock  in  1  requester 1 bus lock (used only with the optional feature).
- mem_we  out  1  to data memory write enable.
- mem_addr  out  AW  to data memory address.
- mem_wdata  out  DW  to data memory data in.
- mem_size  out  2  to data memory size select.
- mem_sext  out  1  to data memory sign-extend.
- mem_rdata  in  DW  from data memory data out.
- busy  out  1  one or more reads in flight.

Behaviour:
- Reset (async, reset_n low): rr_ptr = 0 (port 0 preferred), read-return pipe cleared, lock_held = 0. All outputs 0: gnt, rvalid, rdata, mem_we, mem_addr, mem_wdata, mem_size, mem_sext, busy.
- Handshake:
  - A requester holds req and its attributes stable until it sees gnt.
  - gnt is combinational in the same cycle from req and registered state.
  - Transfer occurs on the rising edge where req and gnt are both 1.
- Arbitration:
  - Only one req high: that port is granted.
  - Both req high: the port equal to rr_ptr is granted.
  - After any grant, rr_ptr <= the port not granted.
  - No req high: rr_ptr is unchanged.
- Memory side:
  - mem_* are driven combinationally from the granted port.
  - With no grant: mem_we = 0, mem_addr/mem_wdata/mem_size/mem_sext = 0.
  - mem_we = granted port's we, gated by its req.
- Read return pipe:
  - Shift register of depth MEM_LATENCY; each stage holds {valid, port}.
  - A granted read enters stage 0. A write enters the pipe as valid = 0.
  - At the final stage, the target port's rvalid is 1 for exactly one cycle.
  - That port's rdata is captured from mem_rdata.
  - rdata holds its last value when rvalid = 0. The other port's rdata is unchanged.
- Throughput: one grant per cycle, back-to-back; reads and writes may interleave freely. Responses return in grant order, exactly MEM_LATENCY cycles after grant.
- busy = OR of pipe valid bits.
- Reset mid-operation: in-flight reads are discarded and produce no rvalid after reset release.
- A req dropped before gnt is legal and is simply not serviced.
- Invalid size (3) is passed through unmodified; handling belongs to the memory.

Optional Feature:
- Macro: DMEM_ARB_LOCK_EN.
- With the macro:
  - A grant to port 1 while p1_lock = 1 sets lock_held.
  - While lock_held, port 0 never receives gnt, and port 1 is granted whenever p1_req.
  - lock_held clears on the first cycle with p1_lock = 0; normal round-robin resumes next cycle.
  - rr_ptr is not updated while lock_held.
- Without the macro: p1_lock is ignored, lock_held does not exist, and arbitration is pure round-robin.

Test Plan:
- Single read: p0 read addr 0x10 (memory 0x12345678), MEM_LATENCY=1 → p0_gnt same cycle; p0_rvalid next cycle with p0_rdata = 0x12345678; p1_rvalid stays 0.
- Contention: p0 and p1 both req continuously for 6 cycles from reset → grants alternate p0, p1, p0, p1, p0, p1; exactly one gnt per cycle.
- Pipelined reads, MEM_LATENCY=3: p1 reads 0x0, 0x4, 0x8 on consecutive cycles → p1_rvalid in 3 consecutive cycles starting 3 cycles after first grant, data in order; busy high throughout.
- Write then read: p0 writes 0xDEADBEEF to 0x20 (word), then p1 reads 0x20 → mem_we = 1 only in write cycle; p1_rdata = 0xDEADBEEF; no rvalid generated for the write.
- Reset during flight: p0 read granted, reset_n low before return → after release, no p0_rvalid; all outputs 0; first contended grant goes to p0.
- With DMEM_ARB_LOCK_EN: p1 lock + req for 4 cycles while p0 req → p1 granted all 4 cycles; p0 granted in the cycle after p1_lock drops.
